ir_adc_scheduler: RTL

- Sequences the shared I2C transaction engine to sample three IR range sensors on an ADS1115-class ADC, one channel at a time, in round-robin order (right, forward, left).
- Per channel: writes the config register to start a single-shot conversion, waits out the conversion time, sets the pointer to the conversion register, then reads 2 bytes.
- Latches the results into per-sensor registers consumed by navigation_fsm.
- Sits between navigation_fsm and the I2C transaction engine.

---
 rtl/ir_adc_pkg.sv | 31 +++
 rtl/cycle_timer.sv | 27 ++
 rtl/ir_adc_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ir_adc_pkg.sv
// rtl/ir_adc_pkg.sv - shared types and constants for the IR ADC scheduler
// ADS1115 pointer values, channel indices and config MSB encoding.
package ir_adc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_CFG_WAIT,
    S_CONV_WAIT,
    S_PTR,
    S_PTR_WAIT,
    S_RD,
    S_RD_WAIT,
    S_STORE
  } adc_sched_state_t;

  localparam logic [7:0] PTR_CONV = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;

  localparam logic [1:0] CH_RIGHT = 2'd0;
  localparam logic [1:0] CH_FWD   = 2'd1;
  localparam logic [1:0] CH_LEFT  = 2'd2;

  // OS=1, single-ended mux AIN<ch> vs GND, PGA=4.096V, single-shot mode
  function automatic logic [7:0] cfg_msb(input logic [1:0] ch);
    logic [2:0] mux;
    mux = 3'd4 + {1'b0, ch};
    return {1'b1, mux, 3'b001, 1'b1};
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - clearable up-counter with programmable terminal value
// Holds at the terminal value; done is high while count equals terminal.
module cycle_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = !clear && (count == terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ir_adc_scheduler.sv
// rtl/ir_adc_scheduler.sv - round-robin ADS1115 sampler for three IR range sensors
// Drives the shared I2C transaction engine: config write, conversion wait, pointer write, 2-byte read.
module ir_adc_scheduler
  import ir_adc_pkg::*;
#(
  parameter int unsigned CONV_WAIT_CYCLES   = 500000,
  parameter int unsigned TXN_TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  CFG_LSB            = 8'h83
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable,
  input  logic        txn_busy,
  input  logic        txn_done,
  input  logic        txn_nack,
  input  logic [15:0] txn_dout,
  output logic        txn_start,
  output logic        txn_rd_nwr,
  output logic [23:0] txn_din,
  output logic [1:0]  txn_bytes,
  output logic [15:0] right_ir,
  output logic [15:0] forward_ir,
  output logic [15:0] left_ir,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic        fault,
  output logic [7:0]  fault_count
);

  localparam logic [31:0] CONV_TERM    = 32'(CONV_WAIT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_TERM = 32'(TXN_TIMEOUT_CYCLES - 1);

  adc_sched_state_t state;
  logic [1:0]       ch;
  logic [1:0]       ch_next;
  logic             in_txn_wait;
  logic             conv_done;
  logic             txn_timeout;
  logic             txn_fail;
  logic [15:0]      sample;

  assign in_txn_wait = (state == S_CFG_WAIT) || (state == S_PTR_WAIT) || (state == S_RD_WAIT);
  assign ch_next     = (ch == CH_LEFT) ? CH_RIGHT : ch + 2'd1;
  // txn_done takes priority over a timeout expiring in the same cycle
  assign txn_fail    = in_txn_wait && (txn_done ? txn_nack : txn_timeout);
  assign sample      = txn_dout[15] ? 16'h0000 : txn_dout;

  cycle_timer #(.WIDTH(32)) u_conv_timer (
    .clk      (clk_in),
    .rst      (reset_in),
    .clear    (state != S_CONV_WAIT),
    .terminal (CONV_TERM),
    .done     (conv_done)
  );

  cycle_timer #(.WIDTH(32)) u_txn_timer (
    .clk      (clk_in),
    .rst      (reset_in),
    .clear    (!in_txn_wait),
    .terminal (TIMEOUT_TERM),
    .done     (txn_timeout)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= S_IDLE;
      ch           <= CH_RIGHT;
      txn_start    <= 1'b0;
      txn_rd_nwr   <= 1'b0;
      txn_din      <= '0;
      txn_bytes    <= '0;
      right_ir     <= '0;
      forward_ir   <= '0;
      left_ir      <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      fault        <= 1'b0;
      fault_count  <= '0;
    end else begin
      txn_start    <= 1'b0;
      sample_valid <= 1'b0;
      if (txn_fail) begin
        fault       <= 1'b1;
        fault_count <= (fault_count == 8'hFF) ? fault_count : fault_count + 8'd1;
        ch          <= ch_next;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable && !txn_busy) state <= S_CFG;
          end
          S_CFG: begin
            if (!txn_busy) begin
              txn_start  <= 1'b1;
              txn_rd_nwr <= 1'b0;
              txn_din    <= {PTR_CFG, cfg_msb(ch), CFG_LSB};
              txn_bytes  <= 2'd3;
              state      <= S_CFG_WAIT;
            end
          end
          S_CFG_WAIT: begin
            if (txn_done) state <= S_CONV_WAIT;
          end
          S_CONV_WAIT: begin
            if (!enable) state <= S_IDLE;
            else if (conv_done) state <= S_PTR;
          end
          S_PTR: begin
            if (!txn_busy) begin
              txn_start  <= 1'b1;
              txn_rd_nwr <= 1'b0;
              txn_din    <= {PTR_CONV, 16'h0000};
              txn_bytes  <= 2'd1;
              state      <= S_PTR_WAIT;
            end
          end
          S_PTR_WAIT: begin
            if (txn_done) state <= S_RD;
          end
          S_RD: begin
            if (!txn_busy) begin
              txn_start  <= 1'b1;
              txn_rd_nwr <= 1'b1;
              txn_din    <= '0;
              txn_bytes  <= 2'd2;
              state      <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            // result is latched here so it lands one cycle after txn_done
            if (txn_done) begin
              case (ch)
                CH_RIGHT: right_ir   <= sample;
                CH_FWD:   forward_ir <= sample;
                default:  left_ir    <= sample;
              endcase
              sample_valid <= 1'b1;
              sample_ch    <= ch;
              state        <= S_STORE;
            end
          end
          S_STORE: begin
            ch    <= ch_next;
            state <= enable ? S_CFG : S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
